// File: rtl/score_n_pkg.sv
// Shared types and width helpers for the Connect-N engine.
package score_n_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      P_A   = 2'b01,
      P_B   = 2'b10
   } cell_t;

   typedef enum logic [1:0] {
      DIR_H,
      DIR_V,
      DIR_D,
      DIR_AD
   } dir_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PLACE,
      ST_SCAN,
      ST_RESOLVE,
      ST_OVER
   } state_t;

   // Bits needed to index 0..n-1 (at least one bit).
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Bits needed to count 0..n.
   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // Row step of a direction's positive side.
   function automatic int dir_dr(input dir_t d);
      case (d)
         DIR_H:   return 0;
         default: return 1;
      endcase
   endfunction

   // Column step of a direction's positive side; anti-diagonal walks up-left.
   function automatic int dir_dc(input dir_t d);
      case (d)
         DIR_H:   return 1;
         DIR_V:   return 0;
         DIR_D:   return 1;
         default: return -1;
      endcase
   endfunction

endpackage

// File: rtl/score_n_engine_scanner.sv
// Sequential win walker: one board cell per cycle over four directions.
module score_n_scanner
   import score_n_pkg::*;
#(
   parameter int unsigned ROWS    = 6,
   parameter int unsigned COLS    = 7,
   parameter int unsigned WIN_LEN = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [idx_w(ROWS)-1:0]     row,
   input  logic [idx_w(COLS)-1:0]     col,
   input  cell_t                      code,
   input  logic [2*ROWS*COLS-1:0]     panel,
   output logic                       done,
   output logic                       win
);

   localparam int unsigned SRW  = cnt_w(ROWS) + 1;
   localparam int unsigned SCW  = cnt_w(COLS) + 1;
   localparam int unsigned RUNW = cnt_w(WIN_LEN);
   localparam logic signed [SRW-1:0] R_LIM = SRW'(ROWS);
   localparam logic signed [SCW-1:0] C_LIM = SCW'(COLS);

   logic                  active;
   dir_t                  dir_q;
   logic                  side_q;
   logic [RUNW-1:0]       run_q;
   logic signed [SRW-1:0] r_q, r0_q;
   logic signed [SCW-1:0] c_q, c0_q;
   cell_t                 code_q;

   dir_t                  dir_n;
   logic signed [SRW-1:0] dr_s, dr_n, dr_walk;
   logic signed [SCW-1:0] dc_s, dc_n, dc_walk;
   logic                  in_bounds;
   logic                  match;
   int                    cell_idx;
   logic [1:0]            cell_v;

   // Step vectors, bounds test and cell select for the probed coordinate.
   always_comb begin
      dir_n     = dir_t'(2'(dir_q) + 2'd1);
      dr_s      = SRW'(dir_dr(dir_q));
      dc_s      = SCW'(dir_dc(dir_q));
      dr_n      = SRW'(dir_dr(dir_n));
      dc_n      = SCW'(dir_dc(dir_n));
      dr_walk   = side_q ? -dr_s : dr_s;
      dc_walk   = side_q ? -dc_s : dc_s;
      in_bounds = !r_q[SRW-1] && !c_q[SCW-1] && (r_q < R_LIM) && (c_q < C_LIM);
      cell_idx  = 0;
      if (in_bounds) begin
         cell_idx = int'(r_q) * int'(COLS) + int'(c_q);
      end
      cell_v = panel[2*cell_idx +: 2];
      match  = in_bounds && (cell_v == code_q);
   end

   // Walk positive then negative side of each direction, stop on a full run.
   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         done   <= 1'b0;
         win    <= 1'b0;
         dir_q  <= DIR_H;
         side_q <= 1'b0;
         run_q  <= '0;
         r_q    <= '0;
         c_q    <= '0;
         r0_q   <= '0;
         c0_q   <= '0;
         code_q <= EMPTY;
      end else begin
         done <= 1'b0;
         if (start) begin
            active <= 1'b1;
            win    <= 1'b0;
            dir_q  <= DIR_H;
            side_q <= 1'b0;
            run_q  <= RUNW'(1);
            r0_q   <= SRW'(row);
            c0_q   <= SCW'(col);
            r_q    <= SRW'(row) + SRW'(dir_dr(DIR_H));
            c_q    <= SCW'(col) + SCW'(dir_dc(DIR_H));
            code_q <= code;
         end else if (active) begin
            if (match && (run_q == RUNW'(WIN_LEN - 1))) begin
               active <= 1'b0;
               done   <= 1'b1;
               win    <= 1'b1;
            end else if (match) begin
               run_q <= run_q + RUNW'(1);
               r_q   <= r_q + dr_walk;
               c_q   <= c_q + dc_walk;
            end else if (!side_q) begin
               side_q <= 1'b1;
               r_q    <= r0_q - dr_s;
               c_q    <= c0_q - dc_s;
            end else if (dir_q == DIR_AD) begin
               active <= 1'b0;
               done   <= 1'b1;
            end else begin
               dir_q  <= dir_n;
               side_q <= 1'b0;
               run_q  <= RUNW'(1);
               r_q    <= r0_q + dr_n;
               c_q    <= c0_q + dc_n;
            end
         end
      end
   end

endmodule

// File: rtl/score_n_engine.sv
// Connect-N game core: board, cursor, turn, heights and move sequencing.
module score_n_engine
   import score_n_pkg::*;
#(
   parameter int unsigned ROWS      = 6,
   parameter int unsigned COLS      = 7,
   parameter int unsigned WIN_LEN   = 4,
   parameter int unsigned START_COL = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   left,
   input  logic                   right,
   input  logic                   put,
   output logic                   player,
   output logic                   invalid_move,
   output logic                   win_a,
   output logic                   win_b,
   output logic                   full_panel,
   output logic                   busy,
   output logic [COLS-1:0]        play,
   output logic [2*ROWS*COLS-1:0] panel
);

   localparam int unsigned CW    = idx_w(COLS);
   localparam int unsigned RW    = idx_w(ROWS);
   localparam int unsigned HW    = cnt_w(ROWS);
   localparam int unsigned MW    = cnt_w(ROWS * COLS);
   localparam int unsigned NCELL = ROWS * COLS;

   state_t        state_q, state_d;
   logic          left_q, right_q, put_q;
   logic          act_left, act_right, act_put;
   logic [CW-1:0] cursor, cursor_d;
   logic [HW-1:0] heights [COLS];
   logic [HW-1:0] col_h;
   logic          col_full;
   logic [MW-1:0] move_cnt;
   logic          do_invalid, clr_invalid, do_place, do_win, do_full, do_toggle;
   logic          scan_done, scan_win;
   cell_t         place_code;
   int            place_idx;

   // Single-action edge decode and cursor-column lookup.
   always_comb begin
      act_left   = left  & ~left_q  & ~(right & ~right_q) & ~(put & ~put_q);
      act_right  = right & ~right_q & ~(left  & ~left_q)  & ~(put & ~put_q);
      act_put    = put   & ~put_q   & ~(left  & ~left_q)  & ~(right & ~right_q);
      col_h      = heights[cursor];
      col_full   = (col_h == HW'(ROWS));
      place_code = player ? P_B : P_A;
      place_idx  = int'(col_h) * int'(COLS) + int'(cursor);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (act_put && !col_full) state_d = ST_PLACE;
         ST_PLACE:   state_d = ST_SCAN;
         ST_SCAN:    if (scan_done) state_d = ST_RESOLVE;
         ST_RESOLVE: begin
            if (scan_win || (move_cnt == MW'(NCELL))) state_d = ST_OVER;
            else                                      state_d = ST_IDLE;
         end
         ST_OVER:    state_d = ST_OVER;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Per-state datapath controls.
   always_comb begin
      cursor_d    = cursor;
      do_invalid  = 1'b0;
      clr_invalid = 1'b0;
      do_place    = 1'b0;
      do_win      = 1'b0;
      do_full     = 1'b0;
      do_toggle   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (act_left) begin
               cursor_d    = (cursor == '0) ? CW'(COLS - 1) : cursor - CW'(1);
               clr_invalid = 1'b1;
            end else if (act_right) begin
               cursor_d    = (cursor == CW'(COLS - 1)) ? '0 : cursor + CW'(1);
               clr_invalid = 1'b1;
            end else if (act_put) begin
               do_invalid  = col_full;
               clr_invalid = !col_full;
            end
         end
         ST_PLACE:   do_place = 1'b1;
         ST_RESOLVE: begin
            if (scan_win)                       do_win    = 1'b1;
            else if (move_cnt == MW'(NCELL))    do_full   = 1'b1;
            else                                do_toggle = 1'b1;
         end
         default: ;
      endcase
   end

   // Board, heights, cursor and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         left_q       <= 1'b0;
         right_q      <= 1'b0;
         put_q        <= 1'b0;
         cursor       <= CW'(START_COL);
         play         <= COLS'(1) << START_COL;
         player       <= 1'b0;
         invalid_move <= 1'b0;
         win_a        <= 1'b0;
         win_b        <= 1'b0;
         full_panel   <= 1'b0;
         busy         <= 1'b0;
         move_cnt     <= '0;
         panel        <= '0;
         for (int c = 0; c < int'(COLS); c++) heights[c] <= '0;
      end else begin
         left_q  <= left;
         right_q <= right;
         put_q   <= put;
         cursor  <= cursor_d;
         play    <= COLS'(1) << cursor_d;
         busy    <= (state_d == ST_PLACE) || (state_d == ST_SCAN) || (state_d == ST_RESOLVE);
         if (do_invalid)  invalid_move <= 1'b1;
         if (clr_invalid) invalid_move <= 1'b0;
         if (do_place) begin
            panel[2*place_idx +: 2] <= place_code;
            heights[cursor]         <= col_h + HW'(1);
            move_cnt                <= move_cnt + MW'(1);
         end
         if (do_win) begin
            win_a <= ~player;
            win_b <= player;
         end
         if (do_full)   full_panel <= 1'b1;
         if (do_toggle) player     <= ~player;
      end
   end

   score_n_scanner #(
      .ROWS    (ROWS),
      .COLS    (COLS),
      .WIN_LEN (WIN_LEN)
   ) u_scan (
      .clk   (clk),
      .rst   (rst),
      .start (do_place),
      .row   (RW'(col_h)),
      .col   (cursor),
      .code  (place_code),
      .panel (panel),
      .done  (scan_done),
      .win   (scan_win)
   );

endmodule

// File: tb/tb_score_n_engine.sv
// Scoreboard bench for score_n_engine on 6x7/4, 5x5/3 and 4x4/4 boards.
module tb_score_n_engine;

   typedef struct packed {
      logic [1:0]  inst;
      logic [6:0]  play;
      logic        player;
      logic        inv;
      logic        wa;
      logic        wb;
      logic        full;
      logic [83:0] panel;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [2:0] left_i, right_i, put_i;

   logic        player0, inv0, wa0, wb0, full0, busy0;
   logic [6:0]  play0;
   logic [83:0] panel0;
   logic        player1, inv1, wa1, wb1, full1, busy1;
   logic [4:0]  play1;
   logic [49:0] panel1;
   logic        player2, inv2, wa2, wb2, full2, busy2;
   logic [3:0]  play2;
   logic [31:0] panel2;

   score_n_engine #(.ROWS(6), .COLS(7), .WIN_LEN(4), .START_COL(0)) u_dut0 (
      .clk(clk), .rst(rst), .left(left_i[0]), .right(right_i[0]), .put(put_i[0]),
      .player(player0), .invalid_move(inv0), .win_a(wa0), .win_b(wb0),
      .full_panel(full0), .busy(busy0), .play(play0), .panel(panel0));

   score_n_engine #(.ROWS(5), .COLS(5), .WIN_LEN(3), .START_COL(0)) u_dut1 (
      .clk(clk), .rst(rst), .left(left_i[1]), .right(right_i[1]), .put(put_i[1]),
      .player(player1), .invalid_move(inv1), .win_a(wa1), .win_b(wb1),
      .full_panel(full1), .busy(busy1), .play(play1), .panel(panel1));

   score_n_engine #(.ROWS(4), .COLS(4), .WIN_LEN(4), .START_COL(0)) u_dut2 (
      .clk(clk), .rst(rst), .left(left_i[2]), .right(right_i[2]), .put(put_i[2]),
      .player(player2), .invalid_move(inv2), .win_a(wa2), .win_b(wb2),
      .full_panel(full2), .busy(busy2), .play(play2), .panel(panel2));

   logic [6:0]  o_play  [3];
   logic [83:0] o_panel [3];
   logic        o_player[3], o_inv[3], o_wa[3], o_wb[3], o_full[3], o_busy[3];

   assign o_play[0] = play0;      assign o_play[1] = 7'(play1);     assign o_play[2] = 7'(play2);
   assign o_panel[0] = panel0;    assign o_panel[1] = 84'(panel1);  assign o_panel[2] = 84'(panel2);
   assign o_player[0] = player0;  assign o_player[1] = player1;     assign o_player[2] = player2;
   assign o_inv[0] = inv0;        assign o_inv[1] = inv1;           assign o_inv[2] = inv2;
   assign o_wa[0] = wa0;          assign o_wa[1] = wa1;             assign o_wa[2] = wa2;
   assign o_wb[0] = wb0;          assign o_wb[1] = wb1;             assign o_wb[2] = wb2;
   assign o_full[0] = full0;      assign o_full[1] = full1;         assign o_full[2] = full2;
   assign o_busy[0] = busy0;      assign o_busy[1] = busy1;         assign o_busy[2] = busy2;

   // Reference model state, one game per instance.
   int m_rows[3], m_cols[3], m_wl[3];
   int brd[3][8][8];
   int m_hgt[3][8];
   int m_cur[3], m_ply[3], m_moves[3];
   bit m_inv[3], m_wa[3], m_wb[3], m_full[3], m_over[3];

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < 3; i++) begin
         m_cur[i] = 0; m_ply[i] = 0; m_moves[i] = 0;
         m_inv[i] = 0; m_wa[i] = 0; m_wb[i] = 0; m_full[i] = 0; m_over[i] = 0;
         for (int r = 0; r < 8; r++) begin
            m_hgt[i][r] = 0;
            for (int c = 0; c < 8; c++) brd[i][r][c] = 0;
         end
      end
   endfunction

   // Exhaustive line search for WIN_LEN equal tokens anywhere on the board.
   function automatic bit m_wins(input int i, input int code);
      int dr[4];
      int dc[4];
      dr = '{0, 1, 1, 1};
      dc = '{1, 0, 1, -1};
      for (int r = 0; r < m_rows[i]; r++)
         for (int c = 0; c < m_cols[i]; c++)
            for (int d = 0; d < 4; d++) begin
               bit ok = 1;
               for (int k = 0; k < m_wl[i]; k++) begin
                  int rr = r + k * dr[d];
                  int cc = c + k * dc[d];
                  if (rr < 0 || rr >= m_rows[i] || cc < 0 || cc >= m_cols[i]) ok = 0;
                  else if (brd[i][rr][cc] != code) ok = 0;
               end
               if (ok) return 1;
            end
      return 0;
   endfunction

   // kind: 0 left, 1 right, 2 put
   function automatic void m_apply(input int i, input int kind);
      int c, h;
      if (m_over[i]) return;
      c = m_cur[i];
      if (kind == 0) begin
         m_cur[i] = (c == 0) ? m_cols[i] - 1 : c - 1;
         m_inv[i] = 0;
      end else if (kind == 1) begin
         m_cur[i] = (c == m_cols[i] - 1) ? 0 : c + 1;
         m_inv[i] = 0;
      end else if (m_hgt[i][c] == m_rows[i]) begin
         m_inv[i] = 1;
      end else begin
         h = m_hgt[i][c];
         m_inv[i] = 0;
         brd[i][h][c] = m_ply[i] + 1;
         m_hgt[i][c]++;
         m_moves[i]++;
         if (m_wins(i, m_ply[i] + 1)) begin
            if (m_ply[i] == 0) m_wa[i] = 1; else m_wb[i] = 1;
            m_over[i] = 1;
         end else if (m_moves[i] == m_rows[i] * m_cols[i]) begin
            m_full[i] = 1;
            m_over[i] = 1;
         end else begin
            m_ply[i] ^= 1;
         end
      end
   endfunction

   function automatic void push_exp(input int i);
      exp_t e;
      e        = '0;
      e.inst   = 2'(i);
      e.play   = 7'(1) << m_cur[i];
      e.player = 1'(m_ply[i]);
      e.inv    = m_inv[i];
      e.wa     = m_wa[i];
      e.wb     = m_wb[i];
      e.full   = m_full[i];
      for (int r = 0; r < m_rows[i]; r++)
         for (int c = 0; c < m_cols[i]; c++)
            e.panel[2*(r*m_cols[i]+c) +: 2] = 2'(brd[i][r][c]);
      sbq.push_back(e);
   endfunction

   task automatic compare_pop();
      exp_t e;
      int   k;
      check_eq("sb_depth", 128'(sbq.size()), 128'(1));
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         k = int'(e.inst);
         check_eq($sformatf("play%0d", k),   128'(o_play[k]),   128'(e.play));
         check_eq($sformatf("player%0d", k), 128'(o_player[k]), 128'(e.player));
         check_eq($sformatf("invalid%0d", k),128'(o_inv[k]),    128'(e.inv));
         check_eq($sformatf("win_a%0d", k),  128'(o_wa[k]),     128'(e.wa));
         check_eq($sformatf("win_b%0d", k),  128'(o_wb[k]),     128'(e.wb));
         check_eq($sformatf("full%0d", k),   128'(o_full[k]),   128'(e.full));
         check_eq($sformatf("panel%0d", k),  128'(o_panel[k]),  128'(e.panel));
         check_eq($sformatf("busy%0d", k),   128'(o_busy[k]),   128'(0));
      end
   endtask

   // Wait for busy to drop, counting edges since the action edge; bounded.
   task automatic wait_idle(input int i, output int cyc);
      cyc = 1;
      while (o_busy[i] && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("busy_timeout", 128'(o_busy[i]), 128'(0));
   endtask

   task automatic act(input int i, input int kind, output int cyc);
      @(negedge clk);
      if (kind == 0) left_i[i] = 1'b1;
      else if (kind == 1) right_i[i] = 1'b1;
      else put_i[i] = 1'b1;
      m_apply(i, kind);
      push_exp(i);
      @(negedge clk);
      left_i[i] = 1'b0; right_i[i] = 1'b0; put_i[i] = 1'b0;
      wait_idle(i, cyc);
      compare_pop();
   endtask

   task automatic goto_col(input int i, input int col);
      int cyc;
      for (int k = 0; k < 8 && m_cur[i] != col; k++) act(i, 1, cyc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; left_i = '0; right_i = '0; put_i = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_reset();
   endtask

   initial begin
      int cyc;
      int seq1[10];
      int seq2[16];
      rst = 1'b1; left_i = '0; right_i = '0; put_i = '0;
      m_rows = '{6, 5, 4};
      m_cols = '{7, 5, 4};
      m_wl   = '{4, 3, 4};
      m_reset();

      // Reset state of all instances.
      do_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         push_exp(i);
         compare_pop();
      end

      // Cursor walks right with wrap.
      for (int k = 0; k < 8; k++) act(0, 1, cyc);
      check_eq("cursor_after_8_right", 128'(o_play[0]), 128'(7'b0000010));

      // Vertical win for A in column 0.
      act(0, 0, cyc);
      for (int k = 0; k < 3; k++) begin
         act(0, 2, cyc); act(0, 1, cyc);
         act(0, 2, cyc); act(0, 0, cyc);
      end
      act(0, 2, cyc);
      check_eq("win_latency", 128'(cyc <= 8 * 3 + 3), 128'(1));
      check_eq("vert_win_a", 128'(o_wa[0]), 128'(1));
      act(0, 2, cyc); act(0, 0, cyc); act(0, 1, cyc);

      // Full column rejects the seventh put.
      do_reset();
      act(0, 1, cyc); act(0, 1, cyc);
      for (int k = 0; k < 7; k++) act(0, 2, cyc);
      check_eq("invalid_full_col", 128'(o_inv[0]), 128'(1));
      act(0, 1, cyc);
      check_eq("invalid_cleared", 128'(o_inv[0]), 128'(0));

      // Diagonal win for B on the 5x5 / 3 board.
      seq1 = '{4, 0, 1, 1, 2, 3, 2, 4, 3, 2};
      foreach (seq1[k]) begin
         goto_col(1, seq1[k]);
         act(1, 2, cyc);
      end
      check_eq("diag_win_b", 128'(o_wb[1]), 128'(1));
      check_eq("diag_no_win_a", 128'(o_wa[1]), 128'(0));
      check_eq("diag_cell00", 128'(o_panel[1][1:0]), 128'(2'b10));
      check_eq("diag_cell11", 128'(o_panel[1][13:12]), 128'(2'b10));
      check_eq("diag_cell22", 128'(o_panel[1][25:24]), 128'(2'b10));

      // No-win fill of the 4x4 board.
      seq2 = '{0, 2, 1, 3, 2, 0, 3, 1, 0, 2, 1, 3, 2, 0, 3, 1};
      foreach (seq2[k]) begin
         goto_col(2, seq2[k]);
         act(2, 2, cyc);
         if (k == 14) check_eq("full_before_last", 128'(o_full[2]), 128'(0));
      end
      check_eq("full_panel", 128'(o_full[2]), 128'(1));
      check_eq("full_no_win", 128'({o_wa[2], o_wb[2]}), 128'(0));

      // Held put places once; simultaneous left+right is ignored.
      do_reset();
      @(negedge clk);
      put_i[0] = 1'b1;
      m_apply(0, 2);
      push_exp(0);
      repeat (20) @(negedge clk);
      put_i[0] = 1'b0;
      wait_idle(0, cyc);
      compare_pop();
      @(negedge clk);
      left_i[0] = 1'b1; right_i[0] = 1'b1;
      push_exp(0);
      @(negedge clk);
      left_i[0] = 1'b0; right_i[0] = 1'b0;
      wait_idle(0, cyc);
      compare_pop();

      // Reset while the scanner is walking.
      @(negedge clk);
      put_i[0] = 1'b1;
      @(negedge clk);
      put_i[0] = 1'b0;
      @(negedge clk);
      check_eq("busy_in_scan", 128'(o_busy[0]), 128'(1));
      rst = 1'b1;
      @(negedge clk);
      m_reset();
      push_exp(0);
      compare_pop();
      rst = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
